ctrl_pc: RTL

CTRL_PC -- requirements
Module: ctrl_pc

---
 rtl/ctrl_pc_pkg.sv | 16 +
 rtl/ctrl_pc_if.sv | 28 ++
 rtl/ctrl_pc_hold_timer.sv | 36 +++
 rtl/ctrl_pc.sv | 100 ++++++++++
 4 files changed

// File: rtl/ctrl_pc_pkg.sv
// rtl/ctrl_pc_pkg.sv - shared core definitions for the PC/pipeline controller
package ctrl_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ctrl_pc_if.sv
// rtl/ctrl_pc_if.sv - execute/fetch/pipeline-control signal bundle around the PC controller
interface ctrl_pc_if;
    logic        jump_en2ctrl;
    logic [31:0] jump_addr2ctrl;
    logic        hold2ctrl;
    logic        ins_ready;
    logic [31:0] ins_addr;
    logic        ins_req;
    logic        hold_pc;
    logic        hold_if_id;
    logic        hold_id_ex;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_err;
    logic        hold_timeout;

    modport master (
        output jump_en2ctrl, jump_addr2ctrl, hold2ctrl, ins_ready,
        input  ins_addr, ins_req, hold_pc, hold_if_id, hold_id_ex,
        input  flush_if_id, flush_id_ex, misalign_err, hold_timeout
    );

    modport slave (
        input  jump_en2ctrl, jump_addr2ctrl, hold2ctrl, ins_ready,
        output ins_addr, ins_req, hold_pc, hold_if_id, hold_id_ex,
        output flush_if_id, flush_id_ex, misalign_err, hold_timeout
    );
endinterface

// File: rtl/ctrl_pc_hold_timer.sv
// rtl/ctrl_pc_hold_timer.sv - consecutive-stall counter with sticky timeout flag
module hold_timer #(
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_cycle,
    output logic hold_timeout
);
    localparam int unsigned    CW    = $clog2(HOLD_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(HOLD_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (hold_cycle) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
            if (cnt_d == LIMIT) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hold_timeout = timeout_q;
endmodule

// File: rtl/ctrl_pc.sv
// rtl/ctrl_pc.sv - PC sequencing and IF/ID/EX hold/flush control
module ctrl_pc
    import ctrl_pc_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR   = 32'h0,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned HOLD_LIMIT  = 16
) (
    input logic      clk,
    input logic      rst,
    ctrl_pc_if.slave bus
);
    localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

    ctrl_state_e   state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic          misalign_q, misalign_d;

    logic ins_req, hold, flush_if_id, flush_id_ex, hold_cycle;

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pc_d        = pc_q;
        misalign_d  = misalign_q;
        ins_req     = 1'b0;
        hold        = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        hold_cycle  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                pc_d        = BOOT_ADDR;
                if (boot_cnt_q <= BW'(1)) state_d = ST_RUN;
                else                      boot_cnt_d = boot_cnt_q - BW'(1);
            end
            default: begin
                ins_req = 1'b1;
                if (bus.jump_en2ctrl) begin
                    // A jump overrides any concurrent stall request.
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    pc_d        = word_align(bus.jump_addr2ctrl);
                    if (bus.jump_addr2ctrl[1:0] != 2'b00) misalign_d = 1'b1;
                    state_d     = ST_RUN;
                end else if (bus.hold2ctrl) begin
                    hold       = 1'b1;
                    hold_cycle = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                    if (bus.ins_ready) pc_d = pc_q + 32'd4;
                    else               flush_if_id = 1'b1;
                end
            end
        endcase

        // Reset cycles look like boot to the rest of the pipeline.
        if (rst) begin
            ins_req     = 1'b0;
            hold        = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BW'(BOOT_CYCLES);
            pc_q       <= BOOT_ADDR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    hold_timer #(.HOLD_LIMIT(HOLD_LIMIT)) u_hold_timer (
        .clk          (clk),
        .rst          (rst),
        .hold_cycle   (hold_cycle),
        .hold_timeout (bus.hold_timeout)
    );

    assign bus.ins_addr     = pc_q;
    assign bus.ins_req      = ins_req;
    assign bus.hold_pc      = hold;
    assign bus.hold_if_id   = hold;
    assign bus.hold_id_ex   = hold;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.flush_id_ex  = flush_id_ex;
    assign bus.misalign_err = misalign_q;
endmodule
